inv_sbox_seq: RTL and testbench
===============================

// Module: inv_sbox_seq
// PURPOSE
//  Iterative AES InvSubBytes unit (FIPS-197 inverse S-box) over a 128-bit state.
//  Processes BYTES_PER_CYCLE bytes per clock, so area scales with the parameter.
//  Uses a valid/ready handshake on both sides.
//  Pairs with the forward sbox block: decrypt-path datapath, and a round-trip checker for sbox.
// PARAMETERS
//  BYTES_PER_CYCLE  4  bytes substituted per BUSY cycle; legal 1,2,4,8,16
//  ITER             16/BYTES_PER_CYCLE (localparam)  BUSY cycles per block
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    asynchronous, active-low reset
//  in_valid   in   1    is_in valid
//  in_ready   out  1    unit can accept a block (state IDLE)
//  is_in      in   128  input state; byte 15 = is_in[127:120] ... byte 0 = [7:0]
//  out_valid  out  1    is_o holds a finished block
//  out_ready  in   1    consumer accepts is_o
//  is_o       out  128  substituted state, same byte order as is_in
//  busy       out  1    high in BUSY
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, work reg=0, is_o=0.
//   Outputs: in_ready=1, out_valid=0, busy=0. All outputs are registered or decoded from state.
//  FSM: IDLE -> BUSY on in_valid&&in_ready; BUSY -> DONE when cnt==ITER-1; DONE -> IDLE on out_ready.
//  IDLE: in_ready=1. Accept edge loads work<=is_in, cnt<=0. in_valid low -> stay IDLE.
//  BUSY: per edge, replace bytes [15-cnt*B .. 16-(cnt+1)*B] (MSB first) of work with InvS(byte); cnt++.
//   B = BYTES_PER_CYCLE. in_ready=0; is_in ignored.
//  Last BUSY edge: updates work, copies the full result to is_o, enters DONE.
//  DONE: out_valid=1, is_o stable until out_ready handshake completes.
//  Latency: accept at edge k -> out_valid high after edge k+ITER (B=4: 4 cycles).
//  Throughput: one block per ITER+2 cycles minimum (no accept in DONE).
//  Simultaneous events:
//   out_ready high on DONE entry: handshake counts in the first DONE cycle; returns to IDLE next edge.
//   in_valid during DONE: not accepted (in_ready=0); producer holds it.
//  Backpressure: DONE held indefinitely while out_ready=0; no data loss.
//  Reset mid-BUSY/DONE: immediate abort to reset values; block discarded, no out_valid.
//  cnt: width clog2(ITER), min 1. Wrap from ITER-1 only via BUSY->DONE.
//  B=16: single BUSY cycle.
//  Inverse table: 256-entry case LUT, InvS(0x63)=0x00, InvS(0x00)=0x52; one LUT instance per byte lane.
// CONFIGURATION
//  INV_SBOX_DUAL_EN defined:
//   Adds input port 'fwd' (1 bit), sampled on the accept edge and held for the whole block.
//   fwd=1: forward S-box applied instead (same lanes, same timing). fwd=0: inverse.
//  INV_SBOX_DUAL_EN undefined: no fwd port and no forward LUTs; always inverse.
// TESTING
//  Reset: rst=0 for 2 cycles, then release -> in_ready=1, out_valid=0, busy=0, is_o=0.
//  Known vector:
//   Input: is_in=128'h638293c31bfc33f5c4eeacea4bc12816, out_ready=1.
//   Response: is_o=128'h00112233445566778899aabbccddeeff; out_valid rises 4 cycles after accept.
//  All-zero input: is_in=0 -> is_o=128'h52525252525252525252525252525252.
//  Backpressure:
//   Hold out_ready=0 for 10 cycles after out_valid.
//   Require: is_o/out_valid stable, in_ready=0 throughout, in_valid ignored.
//   Then 1-cycle out_ready -> in_ready=1 next cycle.
//  Reset abort:
//   Drop rst at cnt==2.
//   Require: all outputs at reset values immediately; no out_valid.
//   A new block after release yields the correct result.
//  DUAL (INV_SBOX_DUAL_EN):
//   fwd=1, is_in=128'h00112233445566778899aabbccddeeff -> is_o=128'h638293c31bfc33f5c4eeacea4bc12816.
//   fwd=0, same input -> inverse result.

Source files
------------

// File: rtl/inv_sbox_seq_if.sv
// Block-level handshake bundle for inv_sbox_seq: input block channel, output block channel, busy flag.
// The producer/consumer side uses the master modport, the substitution unit uses slave.
interface inv_sbox_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] is_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] is_o;
    logic         busy;

    modport master (
        output in_valid, is_in, out_ready,
        input  in_ready, out_valid, is_o, busy
    );

    modport slave (
        input  in_valid, is_in, out_ready,
        output in_ready, out_valid, is_o, busy
    );
endinterface

// File: rtl/inv_sbox_seq.sv
// Iterative AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE lanes per BUSY cycle, MSB bytes first.
// Optional INV_SBOX_DUAL_EN adds a 'fwd' input selecting the forward S-box for the whole block.
module inv_sbox_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef INV_SBOX_DUAL_EN
    input  logic fwd,
`endif
    inv_sbox_seq_if.slave bus
);
    localparam int B    = BYTES_PER_CYCLE;
    localparam int ITER = 16 / B;
    localparam int W    = 8 * B;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t         r_state, w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [127:0]   r_work, r_is_o, w_work_next;
    logic [W-1:0]   w_win, w_sub;
    logic [7:0]     w_off;
    logic           w_accept, w_last;

    // Each table row is indexed by the high nibble; the low nibble picks the byte, MSB first.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[{~x[3:0], 3'b000} +: 8];
    endfunction

`ifdef INV_SBOX_DUAL_EN
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[{~x[3:0], 3'b000} +: 8];
    endfunction

    logic r_fwd;
`endif

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CW'(ITER - 1));
    // Slot ITER-1-cnt counted from the LSB is the MSB-first window for this cycle.
    assign w_off    = 8'(W) * 8'(CW'(ITER - 1) - r_cnt);
    assign w_win    = r_work[w_off +: W];

    for (genvar gi = 0; gi < B; gi++) begin : g_lane
`ifdef INV_SBOX_DUAL_EN
        assign w_sub[gi*8 +: 8] = r_fwd ? fwd_sbox(w_win[gi*8 +: 8]) : inv_sbox(w_win[gi*8 +: 8]);
`else
        assign w_sub[gi*8 +: 8] = inv_sbox(w_win[gi*8 +: 8]);
`endif
    end

    always_comb begin
        w_work_next = r_work;
        w_work_next[w_off +: W] = w_sub;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)        w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_work <= '0;
            r_is_o <= '0;
`ifdef INV_SBOX_DUAL_EN
            r_fwd  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_work <= bus.is_in;
`ifdef INV_SBOX_DUAL_EN
            r_fwd  <= fwd;
`endif
        end else if (r_state == S_BUSY) begin
            r_work <= w_work_next;
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_is_o <= w_work_next;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_BUSY);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.is_o      = r_is_o;
endmodule

// File: tb/tb_inv_sbox_seq.sv
// Directed bench for inv_sbox_seq (BYTES_PER_CYCLE=4): reset, known vectors, backpressure, reset abort,
// and the forward/inverse selection when INV_SBOX_DUAL_EN is defined.
module tb_inv_sbox_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_sbox_seq_if bus_if();
`ifdef INV_SBOX_DUAL_EN
    logic fwd = 1'b0;
`endif

    inv_sbox_seq #(.BYTES_PER_CYCLE(4)) dut (
        .clk (clk),
        .rst (rst),
`ifdef INV_SBOX_DUAL_EN
        .fwd (fwd),
`endif
        .bus (bus_if)
    );

    localparam logic [127:0] VEC_IN   = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] VEC_OUT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ZERO_OUT = 128'h52525252525252525252525252525252;
    localparam logic [127:0] SEQ_INV  = 128'h52e3946686edd30297f962fe27c9997d;
    localparam logic [127:0] ONES_OUT = 128'h7d7d7d7d7d7d7d7d7d7d7d7d7d7d7d7d;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block, then waits (bounded) for out_valid; returns cycles from accept edge.
    task automatic run_block(input logic [127:0] din, input logic ordy, output int cycles);
        bus_if.in_valid  = 1'b1;
        bus_if.is_in     = din;
        bus_if.out_ready = ordy;
        tick();
        chk1("accept_busy", bus_if.busy, 1'b1);
        chk1("accept_in_ready", bus_if.in_ready, 1'b0);
        bus_if.in_valid = 1'b0;
        bus_if.is_in    = {$urandom, $urandom, $urandom, $urandom};
        cycles = 0;
        while (bus_if.out_valid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        $display("block in=%h out=%h latency=%0d", din, bus_if.is_o, cycles);
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.is_in     = '0;
        bus_if.out_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk1("rst_in_ready", bus_if.in_ready, 1'b1);
        chk1("rst_out_valid", bus_if.out_valid, 1'b0);
        chk1("rst_busy", bus_if.busy, 1'b0);
        chk128("rst_is_o", bus_if.is_o, '0);
        rst = 1'b1;
        tick();
        tick();
        chk1("idle_in_ready", bus_if.in_ready, 1'b1);
        chk1("idle_busy", bus_if.busy, 1'b0);

        // Known vector with out_ready already high on DONE entry.
        run_block(VEC_IN, 1'b1, lat);
        chkint("known_latency", lat, 4);
        chk1("known_out_valid", bus_if.out_valid, 1'b1);
        chk128("known_is_o", bus_if.is_o, VEC_OUT);
        chk1("known_done_in_ready", bus_if.in_ready, 1'b0);
        tick();
        chk1("known_ret_in_ready", bus_if.in_ready, 1'b1);
        chk1("known_ret_out_valid", bus_if.out_valid, 1'b0);

        run_block(128'h00112233445566778899aabbccddeeff, 1'b1, lat);
        chkint("seq_latency", lat, 4);
        chk128("seq_is_o", bus_if.is_o, SEQ_INV);
        tick();

        run_block({128{1'b1}}, 1'b1, lat);
        chk128("ones_is_o", bus_if.is_o, ONES_OUT);
        tick();

        // All-zero block held in DONE by backpressure while a new block is offered.
        run_block('0, 1'b0, lat);
        chkint("zero_latency", lat, 4);
        chk128("zero_is_o", bus_if.is_o, ZERO_OUT);
        bus_if.in_valid = 1'b1;
        bus_if.is_in    = VEC_IN;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("bp_out_valid", bus_if.out_valid, 1'b1);
            chk1("bp_in_ready", bus_if.in_ready, 1'b0);
            chk1("bp_busy", bus_if.busy, 1'b0);
            chk128("bp_is_o", bus_if.is_o, ZERO_OUT);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        chk1("bp_release_in_ready", bus_if.in_ready, 1'b1);
        chk1("bp_release_out_valid", bus_if.out_valid, 1'b0);
        tick();
        chk1("bp_idle_busy", bus_if.busy, 1'b0);

        // Abort a block at cnt==2 with an asynchronous reset.
        bus_if.in_valid  = 1'b1;
        bus_if.is_in     = VEC_IN;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        tick();
        tick();
        chk1("abort_pre_busy", bus_if.busy, 1'b1);
        rst = 1'b0;
        #1;
        chk1("abort_in_ready", bus_if.in_ready, 1'b1);
        chk1("abort_busy", bus_if.busy, 1'b0);
        chk1("abort_out_valid", bus_if.out_valid, 1'b0);
        chk128("abort_is_o", bus_if.is_o, '0);
        tick();
        tick();
        chk1("abort_hold_out_valid", bus_if.out_valid, 1'b0);
        rst = 1'b1;
        tick();
        chk1("abort_rel_out_valid", bus_if.out_valid, 1'b0);
        chk1("abort_rel_in_ready", bus_if.in_ready, 1'b1);
        run_block(VEC_IN, 1'b1, lat);
        chkint("after_abort_latency", lat, 4);
        chk128("after_abort_is_o", bus_if.is_o, VEC_OUT);
        tick();

`ifdef INV_SBOX_DUAL_EN
        fwd = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.is_in     = VEC_OUT;
        bus_if.out_ready = 1'b1;
        tick();
        fwd = 1'b0;
        bus_if.in_valid = 1'b0;
        lat = 0;
        while (bus_if.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        $display("block fwd=1 in=%h out=%h latency=%0d", VEC_OUT, bus_if.is_o, lat);
        chkint("dual_fwd_latency", lat, 4);
        chk128("dual_fwd_is_o", bus_if.is_o, VEC_IN);
        tick();
        run_block(VEC_OUT, 1'b1, lat);
        chk128("dual_inv_is_o", bus_if.is_o, SEQ_INV);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
